// File: rtl/sdram_port_responder_pkg.sv
// Shared constants for the SDRAM port responder: FSM encoding, burst length
// and halfword width.
package sdram_port_responder_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_HI    = 3'd1;
  localparam logic [2:0] ST_WR_LO    = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_BURST = 3'd4;

  localparam int BURST_LEN = 8;
  localparam int HW_WIDTH  = 16;

  // Beat offset inside the aligned 16-byte block; 3-bit sum wraps by design.
  function automatic logic [2:0] wrap_off(input logic [2:0] base_off, input logic [2:0] k);
    return base_off + k;
  endfunction

endpackage

// File: rtl/sdram_port_responder_port_ram.sv
// Single-port halfword RAM with per-byte write enables and a registered read.
// Only the read register is reset; the array keeps its contents.
module port_ram
  import sdram_port_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            we,
  input  logic                  re,
  input  logic [HW_WIDTH-1:0]   wdata,
  output logic [HW_WIDTH-1:0]   rdata
);

  logic [HW_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][HW_WIDTH-1:HW_WIDTH/2] <= wdata[HW_WIDTH-1:HW_WIDTH/2];
    if (we[0]) mem[addr][HW_WIDTH/2-1:0]        <= wdata[HW_WIDTH/2-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_port_responder.sv
// SDRAM port responder: two-beat halfword writes and 8-beat wrapping read bursts
// against a local halfword RAM.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | waiting for acc_i; a read latches its base address here
// ST_WR_HI    | writing the upper halfword at adr_i
// ST_WR_LO    | writing the lower halfword at adr_i (= adr+2), ack_o high
// ST_RD_WAIT  | read latency countdown; last cycle fetches beat 0
// ST_RD_BURST | eight data beats, ack_o on beat 0, next beat fetched ahead
module sdram_port_responder
  import sdram_port_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int RD_LATENCY     = 2
) (
  input  logic                sdram_clk,
  input  logic                sdram_rst,
  input  logic                acc_i,
  input  logic                we_i,
  input  logic [31:0]         adr_i,
  input  logic [HW_WIDTH-1:0] dat_i,
  input  logic [1:0]          sel_i,
  output logic                ack_o,
  output logic [31:0]         adr_o,
  output logic [HW_WIDTH-1:0] dat_o
);

  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
  localparam logic [2:0] LAT_LOAD  = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

  logic [2:0]                state, state_nxt;
  logic [31:1]               base;
  logic [31:1]               fetch_adr;
  logic [2:0]                beat;
  logic [2:0]                lat_cnt;
  logic                      rd_issue;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [1:0]                ram_we;

  // Byte addresses are halfword aligned; bit 0 carries no information.
  logic unused_adr_lsb;
  assign unused_adr_lsb = adr_i[0];

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    fetch_adr = base;
    case (state)
      ST_IDLE: begin
        if (acc_i) begin
          if (we_i) begin
            state_nxt = ST_WR_HI;
          end else if (RD_LATENCY == 1) begin
            state_nxt = ST_RD_BURST;
            rd_issue  = 1'b1;
            fetch_adr = adr_i[31:1];
          end else begin
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_WR_HI: state_nxt = ST_WR_LO;
      ST_WR_LO: state_nxt = ST_IDLE;
      ST_RD_WAIT: begin
        if (lat_cnt == 3'd0) begin
          state_nxt = ST_RD_BURST;
          rd_issue  = 1'b1;
        end
      end
      ST_RD_BURST: begin
        if (beat == LAST_BEAT) begin
          state_nxt = ST_IDLE;
        end else begin
          rd_issue  = 1'b1;
          fetch_adr = {base[31:4], wrap_off(base[3:1], beat + 3'd1)};
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst) begin
    if (!sdram_rst) begin
      state   <= ST_IDLE;
      base    <= '0;
      beat    <= '0;
      lat_cnt <= '0;
      adr_o   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && acc_i && !we_i) begin
        base    <= adr_i[31:1];
        lat_cnt <= LAT_LOAD;
      end else if (state == ST_RD_WAIT && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (state == ST_RD_BURST) beat <= (beat == LAST_BEAT) ? 3'd0 : beat + 3'd1;
      // adr_o moves on the same edge the RAM read register does
      if (rd_issue) adr_o <= {fetch_adr, 1'b0};
    end
  end

  assign ack_o    = (state == ST_WR_LO) || (state == ST_RD_BURST && beat == 3'd0);
  assign ram_we   = (state == ST_WR_HI || state == ST_WR_LO) ? sel_i : 2'b00;
  assign ram_addr = rd_issue ? fetch_adr[MEM_ADDR_WIDTH:1] : adr_i[MEM_ADDR_WIDTH:1];

  port_ram #(.ADDR_WIDTH(MEM_ADDR_WIDTH)) u_ram (
    .clk   (sdram_clk),
    .rst_n (sdram_rst),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (rd_issue),
    .wdata (dat_i),
    .rdata (dat_o)
  );

endmodule

// File: tb/tb_sdram_port_responder.sv
// Bench for sdram_port_responder: writes go through a halfword memory model,
// reads push expected beats into a scoreboard that is drained against captures.
module tb_sdram_port_responder;

  localparam int MAW = 12;
  localparam int LAT = 2;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic        acc, we;
  logic [31:0] adr;
  logic [15:0] dat;
  logic [1:0]  sel;
  logic        ack_o;
  logic [31:0] adr_o;
  logic [15:0] dat_o;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mdl  [2**MAW];
  bit          mvld [2**MAW];

  logic [31:0] exp_adr [$];
  logic [15:0] exp_dat [$];
  bit          exp_vld [$];

  logic [31:0] cap_adr [16];
  logic [15:0] cap_dat [16];
  logic        cap_ack [16];
  int          r_cyc, w_cyc;
  bit          r_to, w_to;
  logic        w_extra_ack, r_hold_ack;
  logic [31:0] r_hold_adr;

  always #5 sdram_clk = ~sdram_clk;

  sdram_port_responder #(.MEM_ADDR_WIDTH(MAW), .RD_LATENCY(LAT)) dut (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .acc_i     (acc),
    .we_i      (we),
    .adr_i     (adr),
    .dat_i     (dat),
    .sel_i     (sel),
    .ack_o     (ack_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o)
  );

  function automatic void model_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
    int idx;
    idx = int'(a[MAW:1]);
    if (s[1]) mdl[idx][15:8] = d[15:8];
    if (s[0]) mdl[idx][7:0]  = d[7:0];
    if (s == 2'b11) mvld[idx] = 1'b1;
  endfunction

  function automatic void push_burst(input logic [31:0] base);
    logic [31:0] a;
    logic [2:0]  off;
    int          idx;
    for (int k = 0; k < 8; k++) begin
      off = base[3:1] + 3'(k);
      a   = {base[31:4], off, 1'b0};
      idx = int'(a[MAW:1]);
      exp_adr.push_back(a);
      exp_dat.push_back(mdl[idx]);
      exp_vld.push_back(mvld[idx]);
    end
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [15:0] hi, input logic [15:0] lo,
                          input logic [1:0] shi, input logic [1:0] slo);
    acc = 1'b1; we = 1'b1; adr = a; dat = hi; sel = shi;
    model_write(a, hi, shi);
    w_to = 1'b1; w_cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge sdram_clk);
      if (ack_o) begin w_cyc = i; w_to = 1'b0; break; end
    end
    if (!w_to) begin
      adr = a + 32'd2; dat = lo; sel = slo;
      model_write(a + 32'd2, lo, slo);
    end
    @(negedge sdram_clk);
    w_extra_ack = ack_o;
    acc = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    acc = 1'b1; we = 1'b0; adr = a; sel = 2'b00;
    r_to = 1'b1; r_cyc = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sdram_clk);
      if (ack_o) begin r_cyc = i; r_to = 1'b0; break; end
    end
    acc = 1'b0;
    if (!r_to) begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge sdram_clk);
        cap_adr[k] = adr_o; cap_dat[k] = dat_o; cap_ack[k] = ack_o;
      end
      @(negedge sdram_clk);
      r_hold_adr = adr_o; r_hold_ack = ack_o;
    end
  endtask

  task automatic test_reset();
    sdram_rst = 1'b0; acc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    #12;
    n_vec++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset ack_o: got %b want 0", ack_o); end
    n_vec++; if (adr_o !== 32'h0) begin n_err++; $display("FAIL reset adr_o: got %h want 0", adr_o); end
    n_vec++; if (dat_o !== 16'h0) begin n_err++; $display("FAIL reset dat_o: got %h want 0", dat_o); end
    @(negedge sdram_clk);
    sdram_rst = 1'b1;
    @(negedge sdram_clk);
  endtask

  task automatic test_write();
    do_write(32'h100, 16'hDEAD, 16'hBEEF, 2'b11, 2'b11);
    n_vec++; if (w_to || w_cyc != 2) begin n_err++; $display("FAIL write latency: got %0d (timeout %0b) want 2", w_cyc, w_to); end
    n_vec++; if (w_extra_ack !== 1'b0) begin n_err++; $display("FAIL write single ack: got %b want 0", w_extra_ack); end
    // back-to-back preload of the rest of the 0x100 block
    do_write(32'h104, 16'h1111, 16'h2222, 2'b11, 2'b11);
    n_vec++; if (w_to || w_cyc != 2) begin n_err++; $display("FAIL b2b write latency: got %0d want 2", w_cyc); end
    do_write(32'h108, 16'h3333, 16'h4444, 2'b11, 2'b11);
    do_write(32'h10C, 16'h5555, 16'h6666, 2'b11, 2'b11);
  endtask

  task automatic test_byte_lane();
    logic [31:0] ea; logic [15:0] ed; bit ev;
    do_write(32'h200, 16'h0000, 16'h0000, 2'b11, 2'b11);
    do_write(32'h200, 16'hFFFF, 16'hFFFF, 2'b10, 2'b01);
    push_burst(32'h200);
    do_read(32'h200);
    if (r_to) begin
      n_vec++; n_err++; $display("FAIL byte_lane read: got no ack want ack");
      exp_adr.delete(); exp_dat.delete(); exp_vld.delete();
    end else begin
      n_vec++; if (cap_dat[0] !== 16'hFF00) begin n_err++; $display("FAIL byte_lane 0x200: got %h want ff00", cap_dat[0]); end
      n_vec++; if (cap_dat[1] !== 16'h00FF) begin n_err++; $display("FAIL byte_lane 0x202: got %h want 00ff", cap_dat[1]); end
      for (int k = 0; k < 8; k++) begin
        ea = exp_adr.pop_front(); ed = exp_dat.pop_front(); ev = exp_vld.pop_front();
        n_vec++; if (cap_adr[k] !== ea) begin n_err++; $display("FAIL byte_lane adr beat %0d: got %h want %h", k, cap_adr[k], ea); end
        if (ev) begin
          n_vec++; if (cap_dat[k] !== ed) begin n_err++; $display("FAIL byte_lane dat beat %0d: got %h want %h", k, cap_dat[k], ed); end
        end
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] ea; logic [15:0] ed; bit ev;
    push_burst(32'h10C);
    do_read(32'h10C);
    if (r_to) begin
      n_vec++; n_err++; $display("FAIL wrap read: got no ack want ack");
      exp_adr.delete(); exp_dat.delete(); exp_vld.delete();
    end else begin
      n_vec++; if (r_cyc != LAT) begin n_err++; $display("FAIL wrap latency: got %0d want %0d", r_cyc, LAT); end
      n_vec++; if (cap_adr[2] !== 32'h100) begin n_err++; $display("FAIL wrap point adr: got %h want 100", cap_adr[2]); end
      n_vec++; if (cap_dat[2] !== 16'hDEAD) begin n_err++; $display("FAIL wrap 0x100: got %h want dead", cap_dat[2]); end
      n_vec++; if (cap_dat[3] !== 16'hBEEF) begin n_err++; $display("FAIL wrap 0x102: got %h want beef", cap_dat[3]); end
      for (int k = 0; k < 8; k++) begin
        ea = exp_adr.pop_front(); ed = exp_dat.pop_front(); ev = exp_vld.pop_front();
        n_vec++; if (cap_adr[k] !== ea) begin n_err++; $display("FAIL wrap adr beat %0d: got %h want %h", k, cap_adr[k], ea); end
        if (ev) begin
          n_vec++; if (cap_dat[k] !== ed) begin n_err++; $display("FAIL wrap dat beat %0d: got %h want %h", k, cap_dat[k], ed); end
        end
        n_vec++; if (cap_ack[k] !== 1'(k == 0)) begin n_err++; $display("FAIL wrap ack beat %0d: got %b want %b", k, cap_ack[k], k == 0); end
      end
      n_vec++; if (r_hold_ack !== 1'b0 || r_hold_adr !== cap_adr[7]) begin
        n_err++; $display("FAIL wrap hold: got ack %b adr %h want ack 0 adr %h", r_hold_ack, r_hold_adr, cap_adr[7]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea; logic [15:0] ed; bit ev;
    bit to1, to2; int gap;
    push_burst(32'h100);
    acc = 1'b1; we = 1'b0; adr = 32'h100;
    to1 = 1'b1; to2 = 1'b1; gap = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sdram_clk);
      if (ack_o) begin to1 = 1'b0; break; end
    end
    acc = 1'b0;
    if (!to1) begin
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge sdram_clk);
        cap_adr[k] = adr_o; cap_dat[k] = dat_o; cap_ack[k] = ack_o;
        if (k == 3) begin
          acc = 1'b1; adr = 32'h110;
          push_burst(32'h110);
        end
      end
      for (int i = 1; i <= 16; i++) begin
        @(negedge sdram_clk);
        if (ack_o) begin gap = i; to2 = 1'b0; break; end
      end
      acc = 1'b0;
      if (!to2) begin
        for (int k = 8; k < 16; k++) begin
          if (k > 8) @(negedge sdram_clk);
          cap_adr[k] = adr_o; cap_dat[k] = dat_o; cap_ack[k] = ack_o;
        end
        @(negedge sdram_clk);
      end
    end
    if (to1 || to2) begin
      n_vec++; n_err++; $display("FAIL two_burst ack: got timeout (%0b,%0b) want two bursts", to1, to2);
      exp_adr.delete(); exp_dat.delete(); exp_vld.delete();
    end else begin
      n_vec++; if (gap != LAT + 1) begin n_err++; $display("FAIL two_burst gap: got %0d want %0d", gap, LAT + 1); end
      for (int k = 0; k < 16; k++) begin
        ea = exp_adr.pop_front(); ed = exp_dat.pop_front(); ev = exp_vld.pop_front();
        n_vec++; if (cap_adr[k] !== ea) begin n_err++; $display("FAIL two_burst adr beat %0d: got %h want %h", k, cap_adr[k], ea); end
        if (ev) begin
          n_vec++; if (cap_dat[k] !== ed) begin n_err++; $display("FAIL two_burst dat beat %0d: got %h want %h", k, cap_dat[k], ed); end
        end
        n_vec++; if (cap_ack[k] !== 1'(k % 8 == 0)) begin n_err++; $display("FAIL two_burst ack beat %0d: got %b want %b", k, cap_ack[k], k % 8 == 0); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] ea; logic [15:0] ed; bit ev;
    bit to; int n_ack;
    acc = 1'b1; we = 1'b0; adr = 32'h100;
    to = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sdram_clk);
      if (ack_o) begin to = 1'b0; break; end
    end
    acc = 1'b0;
    n_vec++; if (to) begin n_err++; $display("FAIL rst_burst start: got no ack want ack"); end
    repeat (3) @(negedge sdram_clk);
    sdram_rst = 1'b0;
    #1;
    n_vec++; if (ack_o !== 1'b0 || adr_o !== 32'h0 || dat_o !== 16'h0) begin
      n_err++; $display("FAIL rst_burst outputs: got ack %b adr %h dat %h want 0 0 0", ack_o, adr_o, dat_o);
    end
    repeat (2) @(negedge sdram_clk);
    sdram_rst = 1'b1;
    n_ack = 0;
    repeat (12) begin
      @(negedge sdram_clk);
      if (ack_o) n_ack++;
    end
    n_vec++; if (n_ack != 0) begin n_err++; $display("FAIL rst_burst stray ack: got %0d want 0", n_ack); end
    push_burst(32'h100);
    do_read(32'h100);
    if (r_to) begin
      n_vec++; n_err++; $display("FAIL rst_burst reread: got no ack want ack");
      exp_adr.delete(); exp_dat.delete(); exp_vld.delete();
    end else begin
      for (int k = 0; k < 8; k++) begin
        ea = exp_adr.pop_front(); ed = exp_dat.pop_front(); ev = exp_vld.pop_front();
        n_vec++; if (cap_adr[k] !== ea) begin n_err++; $display("FAIL rst_burst adr beat %0d: got %h want %h", k, cap_adr[k], ea); end
        if (ev) begin
          n_vec++; if (cap_dat[k] !== ed) begin n_err++; $display("FAIL rst_burst dat beat %0d: got %h want %h", k, cap_dat[k], ed); end
        end
      end
    end
  endtask

  task automatic test_alias();
    logic [31:0] ea; logic [15:0] ed; bit ev;
    do_write(32'h0000_2000, 16'h1234, 16'h5678, 2'b11, 2'b11);
    push_burst(32'h0);
    do_read(32'h0);
    if (r_to) begin
      n_vec++; n_err++; $display("FAIL alias read: got no ack want ack");
      exp_adr.delete(); exp_dat.delete(); exp_vld.delete();
    end else begin
      n_vec++; if (cap_dat[0] !== 16'h1234) begin n_err++; $display("FAIL alias 0x0: got %h want 1234", cap_dat[0]); end
      for (int k = 0; k < 8; k++) begin
        ea = exp_adr.pop_front(); ed = exp_dat.pop_front(); ev = exp_vld.pop_front();
        n_vec++; if (cap_adr[k] !== ea) begin n_err++; $display("FAIL alias adr beat %0d: got %h want %h", k, cap_adr[k], ea); end
        if (ev) begin
          n_vec++; if (cap_dat[k] !== ed) begin n_err++; $display("FAIL alias dat beat %0d: got %h want %h", k, cap_dat[k], ed); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**MAW; i++) begin mdl[i] = '0; mvld[i] = 1'b0; end
    test_reset();
    test_write();
    test_byte_lane();
    test_wrap_read();
    test_back_to_back();
    test_reset_mid_burst();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_port_responder.md
SDRAM_PORT_RESPONDER -- requirements
Module: sdram_port_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 12, halfword-index width of the backing memory (2^12 halfwords = 8 KiB).
REQ-002 SHALL have parameter RD_LATENCY, default 2, cycles from read acceptance to first data beat; legal range 1..7.
REQ-003 SHALL have port sdram_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port sdram_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port acc_i  input  1  access request from the port, held high until acknowledged.
REQ-006 SHALL have port we_i  input  1  1 = write access, 0 = read burst; sampled with acc_i.
REQ-007 SHALL have port adr_i  input  32  byte address; during a write it is adr in the first beat and adr+2 in the ack cycle.
REQ-008 SHALL have port dat_i  input  16  write halfword: upper half of the word first, lower half in the ack cycle.
REQ-009 SHALL have port sel_i  input  2  byte enables for dat_i; bit 1 = dat_i[15:8].
REQ-010 SHALL have port ack_o  output  1  one-cycle acknowledge: write completion, or first beat of a read burst.
REQ-011 SHALL have port adr_o  output  32  byte address of the halfword currently on dat_o during read beats.
REQ-012 SHALL have port dat_o  output  16  read data beat.

Function
REQ-013 SHALL implement states IDLE, WR_HI, WR_LO, RD_WAIT and RD_BURST.
REQ-014 In IDLE, acc_i=1 with we_i=1 SHALL enter WR_HI, and acc_i=1 with we_i=0 SHALL latch adr_i and enter RD_WAIT.
REQ-015 In WR_HI, SHALL write dat_i to halfword adr_i[MEM_ADDR_WIDTH:1] under sel_i, then enter WR_LO.
REQ-016 In WR_LO, SHALL drive ack_o=1, write dat_i/sel_i to halfword adr_i[MEM_ADDR_WIDTH:1] (port presents adr+2), then enter IDLE.
REQ-017 Write latency SHALL be acceptance + 2 cycles to ack_o, with exactly one ack_o per write.
REQ-018 In RD_WAIT, SHALL count RD_LATENCY-1 cycles and then enter RD_BURST.
REQ-019 RD_BURST SHALL last exactly 8 consecutive cycles, beats k=0..7.
REQ-020 ack_o SHALL be 1 only at beat k=0.
REQ-021 adr_o SHALL equal {base[31:4], (base[3:1]+k) mod 8, 1'b0}, wrapping within the aligned 16-byte block.
REQ-022 dat_o SHALL equal memory at adr_o in the same cycle.
REQ-023 Outside RD_BURST, ack_o SHALL be 0 and dat_o/adr_o SHALL hold their last values.
REQ-024 After RD_BURST, SHALL return to IDLE and accept the next request no earlier than the following cycle.
REQ-025 A request raised during RD_WAIT or RD_BURST SHALL wait in acc_i and be served from IDLE, never dropped or merged.
REQ-026 acc_i deasserting before ack_o SHALL NOT abort an accepted access; the access completes normally.
REQ-027 Address bits above MEM_ADDR_WIDTH SHALL be ignored (aliasing); adr_i[0] SHALL be ignored.
REQ-028 Back-to-back writes SHALL be allowed with one idle cycle between them (IDLE, WR_HI, WR_LO, IDLE).
REQ-029 A read issued after a write SHALL return the newly written data.

Reset
REQ-030 Asserting sdram_rst (low) SHALL immediately force state IDLE, ack_o=0, adr_o=0, dat_o=0, beat and latency counters=0.
REQ-031 Reset mid-burst or mid-write SHALL abandon the access with no further ack_o; memory content SHALL NOT be reset.
REQ-032 Operation SHALL resume on the first sdram_clk edge after deassertion.

Structure
REQ-033 State encoding, BURST_LEN=8 and the halfword width SHALL live in a shared constants package/include used by the port and the responder.
REQ-034 Memory SHALL be a sub-module port_ram: single-port, 2^MEM_ADDR_WIDTH x 16, two byte write-enables, synchronous read.
REQ-035 RD_BURST SHALL prefetch the next beat address one cycle ahead so beats are gap-free.

Verification
REQ-036 Write: adr 0x100, dat_i 0xDEAD then 0xBEEF, sel 11 -> ack_o exactly 2 cycles after acceptance; halfwords 0x100=DEAD, 0x102=BEEF.
REQ-037 Byte-lane write: sel 10 then 01 over 0xFFFF_FFFF at 0x200, memory preloaded with 0 -> 0x200=FF00, 0x202=00FF.
REQ-038 Wrapping read at adr 0x10C, RD_LATENCY=2 -> ack_o 2 cycles after acceptance; adr_o sequence 10C,10E,100,102,104,106,108,10A; dat_o matches the preload; ack_o high only on the first beat.
REQ-039 Two-burst read: second acc_i raised 3 cycles after the first ack, adr 0x110 -> burst 2 starts only after burst 1 ends; 16 beats total, no overlap.
REQ-040 Reset asserted at beat 3 -> outputs 0 asynchronously, no further ack_o; a read after release returns the stored data.
REQ-041 Alias: write 0x1234 at 0x0000_2000 with MEM_ADDR_WIDTH=12 -> a read at 0x0000_0000 returns 0x1234.
